// File: rtl/range_coalesce.sv
// range_coalesce: fuses an ascending-by-lo stream of inclusive ID ranges
// into disjoint ranges, streams them out through a one-entry output
// register, and accumulates the number of distinct IDs covered.
module range_coalesce #(
    parameter int VAL_WIDTH   = 64,
    parameter int TOTAL_WIDTH = 72
) (
    input  logic                   clock,
    input  logic                   reset_n,
    input  logic                   clear_in,
    input  logic                   valid_in,
    input  logic                   last_in,
    input  logic [VAL_WIDTH-1:0]   lo_in,
    input  logic [VAL_WIDTH-1:0]   hi_in,
    output logic                   ready_out,
    output logic                   valid_out,
    output logic [VAL_WIDTH-1:0]   lo_out,
    output logic [VAL_WIDTH-1:0]   hi_out,
    input  logic                   ready_in,
    output logic [TOTAL_WIDTH-1:0] total_out,
    output logic                   done_out,
    output logic                   err_out
);

    typedef enum logic [1:0] {
        IDLE,
        ACCUM,
        FLUSH,
        DONE
    } state_t;

    state_t state;
    state_t state_next;

    logic [VAL_WIDTH-1:0]   cur_lo;
    logic [VAL_WIDTH-1:0]   cur_hi;
    logic [VAL_WIDTH:0]     cur_hi_plus1;
    logic [TOTAL_WIDTH-1:0] cur_len;

    logic slot_free;
    logic accept;
    logic bad_range;
    logic can_merge;

    logic load_cur;
    logic merge_cur;
    logic emit_cur;
    logic set_err;

    // The output register can take a new range if it is empty or being drained this cycle.
    assign slot_free = !valid_out || ready_in;
    assign ready_out = ((state == IDLE) || (state == ACCUM)) && slot_free && !clear_in;
    assign accept    = valid_in && ready_out;

    // The +1 is done one bit wider so a range ending at all-ones does not wrap and falsely merge with 0.
    assign cur_hi_plus1 = {1'b0, cur_hi} + {{VAL_WIDTH{1'b0}}, 1'b1};
    assign can_merge    = ({1'b0, lo_in} <= cur_hi_plus1);

    // Malformed ranges, and ranges that go backwards while accumulating, are dropped.
    assign bad_range = (lo_in > hi_in) || ((state == ACCUM) && (lo_in < cur_lo));

    // Length is computed in the accumulator width so the full range counts as 2^VAL_WIDTH.
    assign cur_len = {{(TOTAL_WIDTH-VAL_WIDTH){1'b0}}, cur_hi}
                   - {{(TOTAL_WIDTH-VAL_WIDTH){1'b0}}, cur_lo}
                   + {{(TOTAL_WIDTH-1){1'b0}}, 1'b1};

    // State register.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and datapath control: decide whether to load, merge or emit the current range.
    always_comb begin
        state_next = state;
        load_cur   = 1'b0;
        merge_cur  = 1'b0;
        emit_cur   = 1'b0;
        set_err    = 1'b0;
        if (clear_in) begin
            state_next = IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        if (bad_range) begin
                            set_err = 1'b1;
                            if (last_in) begin
                                state_next = DONE;
                            end
                        end else begin
                            load_cur   = 1'b1;
                            state_next = last_in ? FLUSH : ACCUM;
                        end
                    end
                end
                ACCUM: begin
                    if (accept) begin
                        if (bad_range) begin
                            set_err = 1'b1;
                        end else if (can_merge) begin
                            merge_cur = 1'b1;
                        end else begin
                            emit_cur = 1'b1;
                            load_cur = 1'b1;
                        end
                        if (last_in) begin
                            state_next = FLUSH;
                        end
                    end
                end
                FLUSH: begin
                    if (slot_free) begin
                        emit_cur   = 1'b1;
                        state_next = DONE;
                    end
                end
                default: begin
                    state_next = state;
                end
            endcase
        end
    end

    // Datapath: current range, output register, running total and status flags.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            cur_lo    <= '0;
            cur_hi    <= '0;
            valid_out <= 1'b0;
            lo_out    <= '0;
            hi_out    <= '0;
            total_out <= '0;
            done_out  <= 1'b0;
            err_out   <= 1'b0;
        end else if (clear_in) begin
            cur_lo    <= '0;
            cur_hi    <= '0;
            valid_out <= 1'b0;
            total_out <= '0;
            done_out  <= 1'b0;
            err_out   <= 1'b0;
        end else begin
            if (emit_cur) begin
                valid_out <= 1'b1;
                lo_out    <= cur_lo;
                hi_out    <= cur_hi;
                total_out <= total_out + cur_len;
            end else if (valid_out && ready_in) begin
                valid_out <= 1'b0;
            end
            if (load_cur) begin
                cur_lo <= lo_in;
                cur_hi <= hi_in;
            end else if (merge_cur && (hi_in > cur_hi)) begin
                cur_hi <= hi_in;
            end
            if (set_err) begin
                err_out <= 1'b1;
            end
            done_out <= (state_next == DONE);
        end
    end

endmodule

// File: tb/tb_range_coalesce.sv
// tb_range_coalesce: directed-vector bench for range_coalesce with hand-computed expectations.
module tb_range_coalesce;

    localparam int VW = 64;
    localparam int TW = 72;
    localparam logic [VW-1:0] MAXV = '1;

    logic          clock;
    logic          reset_n;
    logic          clear_in;
    logic          valid_in;
    logic          last_in;
    logic [VW-1:0] lo_in;
    logic [VW-1:0] hi_in;
    logic          ready_out;
    logic          valid_out;
    logic [VW-1:0] lo_out;
    logic [VW-1:0] hi_out;
    logic          ready_in;
    logic [TW-1:0] total_out;
    logic          done_out;
    logic          err_out;

    int checks = 0;
    int errors = 0;

    logic [VW-1:0] got_lo[$];
    logic [VW-1:0] got_hi[$];
    logic [VW-1:0] exp_lo[$];
    logic [VW-1:0] exp_hi[$];

    range_coalesce #(.VAL_WIDTH(VW), .TOTAL_WIDTH(TW)) dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .clear_in  (clear_in),
        .valid_in  (valid_in),
        .last_in   (last_in),
        .lo_in     (lo_in),
        .hi_in     (hi_in),
        .ready_out (ready_out),
        .valid_out (valid_out),
        .lo_out    (lo_out),
        .hi_out    (hi_out),
        .ready_in  (ready_in),
        .total_out (total_out),
        .done_out  (done_out),
        .err_out   (err_out)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Record every output transfer; inputs change just after posedge, so negedge sees the settled handshake.
    always @(negedge clock) begin
        if (reset_n && valid_out && ready_in) begin
            got_lo.push_back(lo_out);
            got_hi.push_back(hi_out);
        end
    end

    task automatic check_output(input string tag, input logic [TW-1:0] actual, input logic [TW-1:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
        end
    endtask

    // Present one range and hold it until accepted; entered and left just after a posedge.
    task automatic apply_stimulus(input logic [VW-1:0] lo, input logic [VW-1:0] hi, input logic last);
        int cyc;
        cyc      = 0;
        valid_in = 1'b1;
        lo_in    = lo;
        hi_in    = hi;
        last_in  = last;
        @(negedge clock);
        while (!ready_out && cyc < 100) begin
            @(negedge clock);
            cyc++;
        end
        if (!ready_out) begin
            check_output("accept_timeout", 72'(ready_out), 72'(1));
        end
        @(posedge clock);
        #1;
        valid_in = 1'b0;
        last_in  = 1'b0;
    endtask

    task automatic wait_done();
        int cyc;
        cyc = 0;
        @(negedge clock);
        while (!done_out && cyc < 50) begin
            @(negedge clock);
            cyc++;
        end
        check_output("done", 72'(done_out), 72'(1));
        repeat (2) @(posedge clock);
        #1;
    endtask

    task automatic check_stream(input string tag);
        int n;
        check_output({tag, "_count"}, 72'(got_lo.size()), 72'(exp_lo.size()));
        n = (got_lo.size() < exp_lo.size()) ? got_lo.size() : exp_lo.size();
        for (int i = 0; i < n; i++) begin
            check_output({tag, "_lo"}, 72'(got_lo[i]), 72'(exp_lo[i]));
            check_output({tag, "_hi"}, 72'(got_hi[i]), 72'(exp_hi[i]));
        end
    endtask

    task automatic pulse_clear();
        clear_in = 1'b1;
        @(posedge clock);
        #1;
        clear_in = 1'b0;
        got_lo.delete();
        got_hi.delete();
        exp_lo.delete();
        exp_hi.delete();
    endtask

    task automatic expect_range(input logic [VW-1:0] lo, input logic [VW-1:0] hi);
        exp_lo.push_back(lo);
        exp_hi.push_back(hi);
    endtask

    initial begin
        reset_n  = 1'b0;
        clear_in = 1'b0;
        valid_in = 1'b0;
        last_in  = 1'b0;
        lo_in    = '0;
        hi_in    = '0;
        ready_in = 1'b1;
        repeat (2) @(posedge clock);
        #1;
        check_output("rst_valid", 72'(valid_out), 72'(0));
        check_output("rst_total", total_out, 72'(0));
        check_output("rst_done", 72'(done_out), 72'(0));
        check_output("rst_err", 72'(err_out), 72'(0));
        reset_n = 1'b1;
        @(posedge clock);
        #1;
        check_output("idle_ready", 72'(ready_out), 72'(1));

        // Overlapping chain plus one disjoint range.
        $display("[TB] test 1: overlap merge");
        expect_range(64'd3, 64'd5);
        expect_range(64'd10, 64'd20);
        apply_stimulus(64'd3, 64'd5, 1'b0);
        apply_stimulus(64'd10, 64'd14, 1'b0);
        apply_stimulus(64'd12, 64'd18, 1'b0);
        apply_stimulus(64'd16, 64'd20, 1'b1);
        wait_done();
        check_stream("t1");
        check_output("t1_total", total_out, 72'd14);
        check_output("t1_err", 72'(err_out), 72'(0));
        pulse_clear();
        check_output("clr_done", 72'(done_out), 72'(0));
        check_output("clr_total", total_out, 72'(0));

        // Adjacent ranges fuse.
        $display("[TB] test 2: adjacent merge");
        expect_range(64'd1, 64'd8);
        apply_stimulus(64'd1, 64'd4, 1'b0);
        apply_stimulus(64'd5, 64'd8, 1'b1);
        wait_done();
        check_stream("t2");
        check_output("t2_total", total_out, 72'd8);
        pulse_clear();

        // Downstream stall: block must back-pressure without losing ranges.
        $display("[TB] test 3: backpressure");
        expect_range(64'd1, 64'd1);
        expect_range(64'd3, 64'd3);
        expect_range(64'd5, 64'd5);
        expect_range(64'd7, 64'd7);
        ready_in = 1'b0;
        fork
            begin
                apply_stimulus(64'd1, 64'd1, 1'b0);
                apply_stimulus(64'd3, 64'd3, 1'b0);
                apply_stimulus(64'd5, 64'd5, 1'b0);
                apply_stimulus(64'd7, 64'd7, 1'b1);
            end
            begin
                repeat (3) @(posedge clock);
                @(negedge clock);
                check_output("t3_stall_ready", 72'(ready_out), 72'(0));
                check_output("t3_stall_valid", 72'(valid_out), 72'(1));
                check_output("t3_stall_lo", 72'(lo_out), 72'd1);
                check_output("t3_stall_total", total_out, 72'd1);
                repeat (3) @(posedge clock);
                #1;
                ready_in = 1'b1;
            end
        join
        wait_done();
        check_stream("t3");
        check_output("t3_total", total_out, 72'd4);
        pulse_clear();

        // Unsorted and malformed ranges are dropped and flagged.
        $display("[TB] test 4: error ranges");
        expect_range(64'd10, 64'd20);
        expect_range(64'd40, 64'd41);
        apply_stimulus(64'd10, 64'd20, 1'b0);
        check_output("t4_err_before", 72'(err_out), 72'(0));
        apply_stimulus(64'd5, 64'd6, 1'b0);
        check_output("t4_err_after", 72'(err_out), 72'(1));
        apply_stimulus(64'd30, 64'd25, 1'b0);
        apply_stimulus(64'd40, 64'd41, 1'b1);
        wait_done();
        check_stream("t4");
        check_output("t4_total", total_out, 72'd13);
        check_output("t4_err", 72'(err_out), 72'(1));
        pulse_clear();
        check_output("clr_err", 72'(err_out), 72'(0));

        // Top of the value range: no wrap in the adjacency test or the length.
        $display("[TB] test 5: extremes");
        expect_range(MAXV - 64'd1, MAXV);
        apply_stimulus(MAXV - 64'd1, MAXV, 1'b0);
        apply_stimulus(MAXV, MAXV, 1'b1);
        wait_done();
        check_stream("t5a");
        check_output("t5a_total", total_out, 72'd2);
        pulse_clear();
        expect_range(64'd0, MAXV);
        apply_stimulus(64'd0, MAXV, 1'b1);
        wait_done();
        check_stream("t5b");
        check_output("t5b_total", total_out, 72'h01_0000_0000_0000_0000);
        pulse_clear();

        // Mid-stream asynchronous reset.
        $display("[TB] test 6: reset and clear mid-stream");
        apply_stimulus(64'd1, 64'd2, 1'b0);
        apply_stimulus(64'd5, 64'd6, 1'b0);
        reset_n = 1'b0;
        #1;
        check_output("t6r_valid", 72'(valid_out), 72'(0));
        check_output("t6r_lo", 72'(lo_out), 72'(0));
        check_output("t6r_hi", 72'(hi_out), 72'(0));
        check_output("t6r_total", total_out, 72'(0));
        @(posedge clock);
        #1;
        reset_n = 1'b1;
        got_lo.delete();
        got_hi.delete();
        expect_range(64'd7, 64'd9);
        apply_stimulus(64'd7, 64'd9, 1'b1);
        wait_done();
        check_stream("t6r");
        check_output("t6r_total_end", total_out, 72'd3);
        pulse_clear();

        // Same scenario with a synchronous clear.
        apply_stimulus(64'd1, 64'd2, 1'b0);
        apply_stimulus(64'd5, 64'd6, 1'b0);
        check_output("t6c_total_pre", total_out, 72'd2);
        pulse_clear();
        check_output("t6c_valid", 72'(valid_out), 72'(0));
        check_output("t6c_total", total_out, 72'(0));
        expect_range(64'd7, 64'd9);
        apply_stimulus(64'd7, 64'd9, 1'b1);
        wait_done();
        check_stream("t6c");
        check_output("t6c_total_end", total_out, 72'd3);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
